// File: rtl/clk_div_sched.sv
// rtl/clk_div_sched.sv - shared programmable clock divider with round-robin divisor scheduling
//
// Purpose: owns one divided clock (OUT_CLK) and lets NREQ requesters change its
// divisor. A round-robin arbiter accepts one request at a time; the captured
// divisor is held pending and only applied at the end of a full OUT_CLK period,
// so no runt phase is ever produced.
//
// Ports:
//   CLK      system clock
//   RST      asynchronous reset, active-high
//   en       divider run enable; 0 freezes counter, OUT_CLK and any pending apply
//   req      per-requester level request, held until granted
//   div_req  packed divisors, requester i at bits [i*W +: W]
//   grant    one-hot one-cycle pulse: request accepted, divisor captured
//   busy     a captured divisor is waiting for its period boundary
//   done     one-cycle pulse in the first cycle the new divisor is in force
//   owner    index of the requester whose divisor was last applied
//   div_cur  divisor currently in force
//   OUT_CLK  divided clock (registered)
//   tick     one-cycle pulse coincident with each OUT_CLK rising edge

module clk_div_sched #(
  parameter int NREQ    = 4,
  parameter int W       = 16,
  parameter int DEF_DIV = 3
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     en,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*W-1:0]        div_req,
  output logic [NREQ-1:0]          grant,
  output logic                     busy,
  output logic                     done,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] owner,
  output logic [W-1:0]             div_cur,
  output logic                     OUT_CLK,
  output logic                     tick
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, PEND} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [W-1:0]  counter;
  logic [W-1:0]  div_nxt;
  logic [IW-1:0] owner_nxt;
  logic [IW-1:0] rr_ptr;

  logic [W-1:0]  div_arr [NREQ];
  logic [IW-1:0] win;
  logic [IW-1:0] cand;
  logic          found;
  logic          take;
  logic          apply;
  logic          at_end;
  logic          boundary;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      div_arr[i] = div_req[i*W +: W];
    end
  end

  assign at_end   = (counter == div_cur);
  // End of the high phase closes a full period: the only safe place to swap divisors.
  assign boundary = en && at_end && OUT_CLK;
  assign busy     = (state == PEND);

  // Round-robin search starting at rr_ptr, wrapping past NREQ-1.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(rr_ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    apply     = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          take      = 1'b1;
          state_nxt = PEND;
        end
      end
      PEND: begin
        if (boundary) begin
          apply     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      counter   <= '0;
      OUT_CLK   <= 1'b0;
      div_cur   <= W'(DEF_DIV);
      div_nxt   <= '0;
      owner_nxt <= '0;
      owner     <= '0;
      rr_ptr    <= '0;
      grant     <= '0;
      done      <= 1'b0;
      tick      <= 1'b0;
    end else begin
      grant <= '0;
      done  <= 1'b0;
      tick  <= 1'b0;

      // A grant only captures; the divider keeps running on the old divisor
      // even if this very cycle is a boundary.
      if (take) begin
        grant     <= NREQ'(1) << win;
        div_nxt   <= div_arr[win];
        owner_nxt <= win;
        rr_ptr    <= IW'((int'(win) + 1) % NREQ);
      end

      if (apply) begin
        // New low phase starts cleanly with the new divisor.
        div_cur <= div_nxt;
        owner   <= owner_nxt;
        done    <= 1'b1;
        counter <= '0;
        OUT_CLK <= 1'b0;
      end else if (en) begin
        if (at_end) begin
          counter <= '0;
          OUT_CLK <= ~OUT_CLK;
          tick    <= ~OUT_CLK;
        end else begin
          counter <= counter + W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_sched.sv
// tb/tb_clk_div_sched.sv - scoreboard testbench for clk_div_sched

module tb_clk_div_sched;

  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int IW   = 2;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              en  = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] div_req = '0;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              done;
  logic [IW-1:0]     owner;
  logic [W-1:0]      div_cur;
  logic              OUT_CLK;
  logic              tick;

  clk_div_sched #(.NREQ(NREQ), .W(W), .DEF_DIV(3)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .en      (en),
    .req     (req),
    .div_req (div_req),
    .grant   (grant),
    .busy    (busy),
    .done    (done),
    .owner   (owner),
    .div_cur (div_cur),
    .OUT_CLK (OUT_CLK),
    .tick    (tick)
  );

  always #5 CLK = ~CLK;

  int cyc;
  always @(posedge CLK or posedge RST) begin
    if (RST) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
  } ev_t;

  ev_t exp_grant[$];
  ev_t exp_done[$];
  ev_t exp_tick[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  bit  tick_chk = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, want, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected event at cyc %0d", name, cyc);
  endtask

  task automatic wait_until(input int c);
    int n;
    n = 0;
    while (cyc != c && n < 70000) begin
      @(negedge CLK);
      n++;
    end
    if (cyc != c) chk("wait_timeout", cyc, c);
  endtask

  task automatic set_div(input int i, input logic [W-1:0] v);
    div_req[i*W +: W] = v;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    en  = 1'b0;
    req = '0;
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_out_clk", OUT_CLK, 0);
    chk("rst_div_cur", div_cur, 3);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_owner", owner, 0);
    chk("rst_tick", tick, 0);
    en  = 1'b1;
    RST = 1'b0;
  endtask

  task automatic monitor_loop();
    ev_t e;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        if (grant != '0) begin
          if (exp_grant.size() == 0) unexpected("grant");
          else begin
            e = exp_grant.pop_front();
            chk("grant_cycle", cyc, e.cyc);
            chk("grant_vec", 32'(grant), e.a);
          end
        end
        if (done) begin
          if (exp_done.size() == 0) unexpected("done");
          else begin
            e = exp_done.pop_front();
            chk("done_cycle", cyc, e.cyc);
            chk("done_owner", 32'(owner), e.a);
            chk("done_div_cur", 32'(div_cur), e.b);
          end
        end
        if (tick && tick_chk) begin
          if (exp_tick.size() == 0) unexpected("tick");
          else begin
            e = exp_tick.pop_front();
            chk("tick_cycle", cyc, e.cyc);
          end
        end
      end
    end
  endtask

  initial begin
    fork
      monitor_loop();
    join_none

    // Default divisor 3, then requester 2 switches to divisor 1 mid-low-phase.
    set_div(2, 16'd1);
    do_reset();
    exp_tick.push_back('{4, 0, 0});
    exp_tick.push_back('{12, 0, 0});
    exp_tick.push_back('{18, 0, 0});
    exp_tick.push_back('{22, 0, 0});
    exp_grant.push_back('{10, 32'h4, 0});
    exp_done.push_back('{16, 2, 1});
    tick_chk = 1'b1;
    wait_until(3);  chk("a_low_end", OUT_CLK, 0);
    wait_until(4);  chk("a_rise", OUT_CLK, 1);
    wait_until(7);  chk("a_high_end", OUT_CLK, 1);
    wait_until(8);  chk("a_fall", OUT_CLK, 0); chk("a_idle_busy", busy, 0);
    wait_until(9);  req = 4'b0100;
    wait_until(10); chk("a_busy", busy, 1); req = '0;
    wait_until(15); chk("a_old_div", div_cur, 3); chk("a_busy_hold", busy, 1);
    wait_until(16); chk("a_new_div", div_cur, 1); chk("a_owner", owner, 2);
    chk("a_apply_low", OUT_CLK, 0); chk("a_busy_clr", busy, 0);
    wait_until(18); chk("a_p4_high", OUT_CLK, 1);
    wait_until(20); chk("a_p4_low", OUT_CLK, 0);
    wait_until(24); tick_chk = 1'b0;
    chk("a_tick_q", exp_tick.size(), 0);

    // Round robin over 0,1,3 from pointer 0, then divisor 0 and 0xFFFF.
    set_div(0, 16'd3);
    set_div(1, 16'd1);
    set_div(2, 16'd7);
    set_div(3, 16'd0);
    do_reset();
    exp_grant.push_back('{2, 32'h1, 0});
    exp_grant.push_back('{9, 32'h2, 0});
    exp_grant.push_back('{17, 32'h8, 0});
    exp_grant.push_back('{25, 32'h2, 0});
    exp_done.push_back('{8, 0, 3});
    exp_done.push_back('{16, 1, 1});
    exp_done.push_back('{20, 3, 0});
    exp_done.push_back('{26, 1, 32'hFFFF});
    wait_until(1);  req = 4'b1011;
    wait_until(2);  req = 4'b1010; chk("b_busy", busy, 1);
    wait_until(7);  chk("b_busy_hold", busy, 1);
    wait_until(8);  chk("b_same_div", div_cur, 3); chk("b_busy_clr", busy, 0);
    wait_until(9);  req = 4'b1000;
    wait_until(16); chk("b_div1", div_cur, 1);
    wait_until(17); req = '0;
    wait_until(20); chk("b_div0", div_cur, 0); chk("b_owner3", owner, 3);
    wait_until(21); chk("c_tog1", OUT_CLK, 1);
    wait_until(22); chk("c_tog0", OUT_CLK, 0);
    wait_until(23); chk("c_tog1b", OUT_CLK, 1);
    wait_until(24); req = 4'b0010; set_div(1, 16'hFFFF);
    wait_until(25); req = '0;
    wait_until(26); chk("c_max_div", div_cur, 16'hFFFF);
    wait_until(65561); chk("c_long_low", OUT_CLK, 0); chk("c_no_tick", tick, 0);
    wait_until(65562); chk("c_wrap_rise", OUT_CLK, 1); chk("c_wrap_tick", tick, 1);
    wait_until(65563); chk("c_wrap_stable", OUT_CLK, 1);

    // Grant coincides with a boundary: old divisor keeps this period.
    set_div(2, 16'd1);
    do_reset();
    exp_grant.push_back('{8, 32'h4, 0});
    exp_done.push_back('{16, 2, 1});
    wait_until(7);  chk("d_pre_bound", OUT_CLK, 1); req = 4'b0100;
    wait_until(8);  chk("d_bound_fall", OUT_CLK, 0); chk("d_keep_div", div_cur, 3);
    chk("d_busy", busy, 1); req = '0;
    wait_until(11); chk("d_old_low", OUT_CLK, 0);
    wait_until(12); chk("d_old_rise", OUT_CLK, 1);
    wait_until(15); chk("d_still_old", div_cur, 3);
    wait_until(16); chk("d_applied", div_cur, 1); chk("d_busy_clr", busy, 0);
    wait_until(20);

    // Freeze while pending, then reset discards a pending divisor.
    set_div(0, 16'd0);
    set_div(3, 16'd5);
    do_reset();
    exp_grant.push_back('{2, 32'h1, 0});
    exp_grant.push_back('{29, 32'h8, 0});
    exp_done.push_back('{28, 0, 0});
    wait_until(1);  req = 4'b0001;
    wait_until(2);  req = '0;
    wait_until(5);  en = 1'b0;
    wait_until(6);  chk("e_frz_out", OUT_CLK, 1); chk("e_frz_busy", busy, 1);
    wait_until(15); chk("e_frz_out2", OUT_CLK, 1); chk("e_frz_tick", tick, 0);
    wait_until(25); chk("e_frz_out3", OUT_CLK, 1); chk("e_frz_busy3", busy, 1); en = 1'b1;
    wait_until(27); chk("e_resume_busy", busy, 1);
    wait_until(28); chk("e_applied", div_cur, 0); chk("e_busy_clr", busy, 0);
    req = 4'b1000;
    wait_until(29); req = '0;
    chk("e_pre_rst_busy", busy, 1); chk("e_pre_rst_out", OUT_CLK, 1);
    #1 RST = 1'b1;
    #1;
    chk("e_rst_busy", busy, 0);
    chk("e_rst_div", div_cur, 3);
    chk("e_rst_out", OUT_CLK, 0);
    chk("e_rst_owner", owner, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    wait_until(20);
    chk("e_discarded", div_cur, 3);

    chk("grant_q_left", exp_grant.size(), 0);
    chk("done_q_left", exp_done.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
